ose_encoder_gen: RTL and testbench



---
 rtl/ose_encoder_gen.sv | 154 +++++++++++++++
 tb/tb_ose_encoder_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ose_encoder_gen.sv
`default_nettype none
// ============================================================================
// Module   : ose_encoder_gen
// Purpose  : Quadrature a/b generator; emits Gray-coded detents for a decoder.
//            Optional contact-bounce emulation: OSE_ENCODER_GEN_BOUNCE_EN.
// Revision : 1.0  initial release
// ============================================================================
module ose_encoder_gen #(
    parameter int STEP_DIV = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] steps,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             a,
    output logic             b
);

    localparam int c_DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(STEP_DIV - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_FIN  = 2'd2;

    logic [1:0]         r_state, w_state_nxt;
    logic               r_dir, w_dir_nxt;
    logic [CNT_W-1:0]   r_remaining, w_remaining_nxt;
    logic [c_DIV_W-1:0] r_div_cnt, w_div_cnt_nxt;
    logic [1:0]         r_phase, w_phase_nxt;
    logic               r_abort_pending, w_abort_pending_nxt;
    logic               w_busy_nxt, w_done_nxt, w_a_nxt, w_b_nxt;
    logic               w_wrap, w_end;
    logic [1:0]         w_phase_inc, w_ab_new;

`ifdef OSE_ENCODER_GEN_BOUNCE_EN
    logic [1:0]         r_bnc_cnt, w_bnc_cnt_nxt;
    logic [1:0]         r_bnc_mask, w_bnc_mask_nxt;
`endif

    // Phase 0 is the 00 rest position; down is the up pattern with a/b swapped.
    function automatic logic [1:0] f_pattern(input logic up, input logic [1:0] ph);
        logic [1:0] v;
        v = {ph[1] ^ ph[0], ph[1]};
        return up ? v : {v[0], v[1]};
    endfunction

    assign w_wrap      = (r_state == c_RUN) && (r_div_cnt == c_DIV_LAST);
    assign w_phase_inc = r_phase + 2'd1;
    assign w_ab_new    = f_pattern(r_dir, w_phase_inc);
    assign w_end       = w_wrap && (r_phase == 2'd3) &&
                         ((r_remaining == CNT_W'(1)) || r_abort_pending);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= c_IDLE;
            r_dir           <= 1'b0;
            r_remaining     <= '0;
            r_div_cnt       <= '0;
            r_phase         <= 2'd0;
            r_abort_pending <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            a               <= 1'b0;
            b               <= 1'b0;
`ifdef OSE_ENCODER_GEN_BOUNCE_EN
            r_bnc_cnt       <= 2'd0;
            r_bnc_mask      <= 2'd0;
`endif
        end else begin
            r_state         <= w_state_nxt;
            r_dir           <= w_dir_nxt;
            r_remaining     <= w_remaining_nxt;
            r_div_cnt       <= w_div_cnt_nxt;
            r_phase         <= w_phase_nxt;
            r_abort_pending <= w_abort_pending_nxt;
            busy            <= w_busy_nxt;
            done            <= w_done_nxt;
            a               <= w_a_nxt;
            b               <= w_b_nxt;
`ifdef OSE_ENCODER_GEN_BOUNCE_EN
            r_bnc_cnt       <= w_bnc_cnt_nxt;
            r_bnc_mask      <= w_bnc_mask_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start) w_state_nxt = (steps != '0) ? c_RUN : c_FIN;
            c_RUN:   if (w_end) w_state_nxt = c_FIN;
            c_FIN:   w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_dir_nxt           = r_dir;
        w_remaining_nxt     = r_remaining;
        w_div_cnt_nxt       = r_div_cnt;
        w_phase_nxt         = r_phase;
        w_abort_pending_nxt = r_abort_pending;
        w_a_nxt             = a;
        w_b_nxt             = b;
        w_busy_nxt          = (w_state_nxt == c_RUN);
        w_done_nxt          = (w_state_nxt == c_FIN);
`ifdef OSE_ENCODER_GEN_BOUNCE_EN
        w_bnc_cnt_nxt       = r_bnc_cnt;
        w_bnc_mask_nxt      = r_bnc_mask;
`endif
        case (r_state)
            c_IDLE: begin
                if (start && (steps != '0)) begin
                    w_dir_nxt       = dir;
                    w_remaining_nxt = steps;
                    w_div_cnt_nxt   = '0;
                    w_phase_nxt     = 2'd0;
                end
            end
            c_RUN: begin
                if (abort) w_abort_pending_nxt = 1'b1;
                if (w_wrap) begin
                    w_div_cnt_nxt = '0;
                    w_phase_nxt   = w_phase_inc;
                    {w_a_nxt, w_b_nxt} = w_ab_new;
                    if (r_phase == 2'd3) w_remaining_nxt = r_remaining - CNT_W'(1);
                end else begin
                    w_div_cnt_nxt = r_div_cnt + c_DIV_W'(1);
                end
            end
            default: ;
        endcase
        if (w_state_nxt == c_IDLE) w_abort_pending_nxt = 1'b0;
`ifdef OSE_ENCODER_GEN_BOUNCE_EN
        // Toggling the changed line twice yields new, old, new; finishes after a FIN.
        if (w_wrap) begin
            w_bnc_mask_nxt = {a ^ w_ab_new[1], b ^ w_ab_new[0]};
            w_bnc_cnt_nxt  = 2'd2;
        end else if (r_bnc_cnt != 2'd0) begin
            w_a_nxt        = a ^ r_bnc_mask[1];
            w_b_nxt        = b ^ r_bnc_mask[0];
            w_bnc_cnt_nxt  = r_bnc_cnt - 2'd1;
        end
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_ose_encoder_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ose_encoder_gen
// Purpose  : Self-checking bench: vector table, reset/abort sequences, random runs.
// Revision : 1.0  initial release
// ============================================================================
module tb_ose_encoder_gen;

    localparam int SD = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          dir = 1'b0;
    logic [CW-1:0] steps = '0;
    logic          abort = 1'b0;
    logic          busy, done, a, b;

    int n_checks = 0;
    int n_errors = 0;

    ose_encoder_gen #(.STEP_DIV(SD), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .steps(steps),
        .abort(abort), .busy(busy), .done(done), .a(a), .b(b)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        bit    d;
        int    n;
        int    ta;
        bit    ab_idle;
        bit    sb;
        int    exp_tr;
        int    exp_dt;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Position q (in phases since start) along the detent cycle.
    function automatic logic [1:0] ref_ab(input bit up, input int q);
        case (q % 4)
            0:       return 2'b00;
            1:       return up ? 2'b10 : 2'b01;
            2:       return 2'b11;
            default: return up ? 2'b01 : 2'b10;
        endcase
    endfunction

    // Detents emitted: abort seen at edge ta+1 stops at the first detent end after it.
    function automatic int model_detents(input int n, input int ta);
        int lim;
        if (n == 0) return 0;
        if (ta < 0) return n;
        lim = (ta + 1) / (4 * SD) + 1;
        return (lim < n) ? lim : n;
    endfunction

    task automatic run(input vec_t v);
        int D, L, busy_err, ab_err, done_cnt, done_t, trans, gray_err;
        logic [1:0] prev, ab, exp_ab;
        bit chk;
        D = model_detents(v.n, v.ta);
        L = 4 * D * SD;
        busy_err = 0; ab_err = 0; done_cnt = 0; done_t = -1; trans = 0; gray_err = 0;
        prev = 2'b00;
        @(negedge clk);
        if (v.ab_idle) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        start = 1'b1; dir = v.d; steps = CW'(v.n);
        @(negedge clk);
        for (int t = 0; t <= L + 3; t++) begin
            start = (v.sb && t == 10);
            if (v.sb && t == 10) begin
                dir = ~v.d;
                steps = CW'(7);
            end
            abort = (t == v.ta);
            ab = {a, b};
            exp_ab = (t < L) ? ref_ab(v.d, t / SD) : 2'b00;
`ifdef OSE_ENCODER_GEN_BOUNCE_EN
            chk = (t < L) ? (t % SD == SD - 1) : (t >= L + 2);
`else
            chk = 1'b1;
`endif
            if (chk && ab !== exp_ab) ab_err++;
            if (busy !== (t < L)) busy_err++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_t < 0) done_t = t;
            end
            if (ab !== prev) begin
                trans++;
                if ((ab ^ prev) != 2'b01 && (ab ^ prev) != 2'b10) gray_err++;
            end
            prev = ab;
            @(negedge clk);
        end
        start = 1'b0; abort = 1'b0;
        check({v.name, "_ab_wave"}, ab_err, 0);
        check({v.name, "_busy"}, busy_err, 0);
        check({v.name, "_done_cnt"}, done_cnt, 1);
        check({v.name, "_done_t"}, done_t, v.exp_dt);
        check({v.name, "_gray"}, gray_err, 0);
`ifndef OSE_ENCODER_GEN_BOUNCE_EN
        check({v.name, "_trans"}, trans, v.exp_tr);
`endif
    endtask

    initial begin
        vec_t vecs[8];
        vec_t rv;
        int cnt_done, cnt_act;

        vecs[0] = '{"up3_sbusy",  1'b1, 3,   -1, 1'b0, 1'b1, 12,   48};
        vecs[1] = '{"down1",      1'b0, 1,   -1, 1'b0, 1'b0, 4,    16};
        vecs[2] = '{"zero",       1'b1, 0,   -1, 1'b0, 1'b0, 0,    0};
        vecs[3] = '{"abort5",     1'b1, 5,   25, 1'b1, 1'b0, 8,    32};
        vecs[4] = '{"down2",      1'b0, 2,   -1, 1'b0, 1'b0, 8,    32};
        vecs[5] = '{"abort_last", 1'b1, 2,   31, 1'b0, 1'b0, 8,    32};
        vecs[6] = '{"max255",     1'b1, 255, -1, 1'b0, 1'b0, 1020, 4080};
        vecs[7] = '{"abort_d1",   1'b0, 4,   3,  1'b0, 1'b0, 4,    16};

        repeat (3) @(negedge clk);
        check("reset_ab", int'({a, b}), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run(vecs[i]);

        // Asynchronous reset mid-phase, then no trailing done pulse.
        start = 1'b1; dir = 1'b1; steps = CW'(3);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst_ab", int'({a, b}), int'(ref_ab(1'b1, 1)));
        check("pre_rst_busy", int'(busy), 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_ab", int'({a, b}), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b1;
        cnt_done = 0; cnt_act = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (done === 1'b1) cnt_done++;
            if (busy !== 1'b0 || {a, b} !== 2'b00) cnt_act++;
        end
        check("post_rst_done", cnt_done, 0);
        check("post_rst_idle", cnt_act, 0);

        for (int i = 0; i < 24; i++) begin
            rv.name    = $sformatf("rand%0d", i);
            rv.d       = 1'($urandom_range(0, 1));
            rv.n       = int'($urandom_range(0, 6));
            rv.ab_idle = 1'($urandom_range(0, 1));
            rv.sb      = 1'($urandom_range(0, 1));
            rv.ta      = (rv.n > 0 && $urandom_range(0, 1) == 1)
                         ? int'($urandom_range(0, 4 * rv.n * SD - 1)) : -1;
            rv.exp_tr  = 4 * model_detents(rv.n, rv.ta);
            rv.exp_dt  = rv.exp_tr * SD;
            run(rv);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
